// File: rtl/gs_bfu_seq_pkg.sv
// Shared definitions for the Gentleman-Sande butterfly slice:
// default datapath width and the sequencer state encoding.
package gs_bfu_seq_pkg;

  // Default operand width; the modulus must satisfy P < 2^(DATAWIDTH-1).
  localparam int unsigned DATAWIDTH = 16;

  // Sequencer states, shared with the INTT controller.
  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_MUL  = 2'd1,
    GS_HALF = 2'd2,
    GS_DONE = 2'd3
  } gs_state_t;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: out = (in1 + in2) mod P.
// P is supplied as its two's complement negation _p.
module mod_add
  import gs_bfu_seq_pkg::*;
#(
  parameter int unsigned DW = DATAWIDTH
) (
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] _p,
  output logic [DW-1:0] out
);

  logic [DW-1:0] p;
  logic [DW:0]   sum;

  // Recover P, form the DW+1 bit sum, subtract P once if needed.
  always_comb begin
    p   = ~_p + 1'b1;
    sum = {1'b0, in1} + {1'b0, in2};
    if (sum >= {1'b0, p}) begin
      out = DW'(sum - {1'b0, p});
    end else begin
      out = DW'(sum);
    end
  end

endmodule

// File: rtl/mod_sub.sv
// Combinational modular subtractor: out = in1 - in2, plus P on borrow.
// Also serves as a conditional "subtract P" reducer when in2 = P.
module mod_sub
  import gs_bfu_seq_pkg::*;
#(
  parameter int unsigned DW = DATAWIDTH
) (
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] _p,
  output logic [DW-1:0] out
);

  logic [DW-1:0] p;
  logic [DW:0]   diff;

  // DW+1 bit difference; the top bit flags a borrow that P must repair.
  always_comb begin
    p    = ~_p + 1'b1;
    diff = {1'b0, in1} - {1'b0, in2};
    if (diff[DW]) begin
      out = DW'(diff + {1'b0, p});
    end else begin
      out = diff[DW-1:0];
    end
  end

endmodule

// File: rtl/gs_bfu_seq.sv
// Sequential Gentleman-Sande butterfly:
//   out_a = (a + b) mod P, out_b = ((a - b) * w) mod P,
// with a bit-serial MSB-first modular multiply. Defining INTT_HALF_EN
// adds a halving step that scales both outputs by 2^-1 mod P.
module gs_bfu_seq
  import gs_bfu_seq_pkg::*;
#(
  parameter int unsigned DW = DATAWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] _p,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DW - 1);

  gs_state_t     state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] s, d, w, acc;
  logic [DW-1:0] p;
  logic [DW-1:0] s_in, d_in, acc_dbl, acc_sum, acc_next;

  assign p = ~_p + 1'b1;

  mod_add #(.DW(DW)) u_add_s   (.in1(in_a), .in2(in_b), ._p(_p), .out(s_in));
  mod_sub #(.DW(DW)) u_sub_d   (.in1(in_a), .in2(in_b), ._p(_p), .out(d_in));
  // 2*acc < 2P fits in DW bits, so subtracting P with wrap repair reduces it.
  mod_sub #(.DW(DW)) u_sub_dbl (.in1(acc << 1), .in2(p), ._p(_p), .out(acc_dbl));
  mod_add #(.DW(DW)) u_add_acc (.in1(acc_dbl), .in2(d), ._p(_p), .out(acc_sum));

  // One MSB-first multiply step: double, then add d when the twiddle bit is set.
  always_comb begin
    acc_next = acc_dbl;
    if (w[cnt]) begin
      acc_next = acc_sum;
    end
  end

`ifdef INTT_HALF_EN
  logic [DW:0]   s_ext, acc_ext;
  logic [DW-1:0] s_half, acc_half;

  // Divide by two mod P: odd values are made even by adding P at DW+1 bits.
  always_comb begin
    s_ext    = {1'b0, s}   + (s[0]   ? {1'b0, p} : '0);
    acc_ext  = {1'b0, acc} + (acc[0] ? {1'b0, p} : '0);
    s_half   = s_ext[DW:1];
    acc_half = acc_ext[DW:1];
  end
`endif

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GS_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      cnt       <= '0;
      s         <= '0;
      d         <= '0;
      w         <= '0;
      acc       <= '0;
    end else begin
      case (state)
        GS_IDLE: begin
          if (in_valid) begin
            s        <= s_in;
            d        <= d_in;
            w        <= in_w;
            acc      <= '0;
            cnt      <= CNT_MAX;
            in_ready <= 1'b0;
            state    <= GS_MUL;
          end
        end
        GS_MUL: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
`ifdef INTT_HALF_EN
            state     <= GS_HALF;
`else
            state     <= GS_DONE;
            out_valid <= 1'b1;
            out_a     <= s;
            out_b     <= acc_next;
`endif
          end
        end
`ifdef INTT_HALF_EN
        GS_HALF: begin
          state     <= GS_DONE;
          out_valid <= 1'b1;
          out_a     <= s_half;
          out_b     <= acc_half;
        end
`endif
        GS_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= GS_IDLE;
          end
        end
        default: begin
          state    <= GS_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/gs_bfu_seq.md
Name: gs_bfu_seq

Overview:
- Sequential Gentleman-Sande (inverse-NTT) butterfly, the decimation-in-frequency counterpart of the forward Cooley-Tukey datapath built from mod_add.
- Takes one operand pair (a, b) and twiddle w, and returns:
  - out_a = (a + b) mod P
  - out_b = ((a − b)·w) mod P
  - both optionally halved mod P for INTT scaling.
- The multiply is bit-serial (interleaved shift-add modular reduction), so the block has a valid/ready handshake on both sides.

Parameters:
- DW, `datawidth, operand width; P < 2^(DW-1) required.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- _p  in  DW  two's complement negation of modulus P (~P+1), quasi-static; same convention as mod_add.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair.
- in_a  in  DW  operand a, in [0,P).
- in_b  in  DW  operand b, in [0,P).
- in_w  in  DW  twiddle, in [0,P).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_a  out  DW  sum result.
- out_b  out  DW  difference×twiddle result.

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - state=IDLE, in_ready=1, out_valid=0, out_a=0, out_b=0, counter=0.
  - Applies mid-operation from any state: the in-flight result is discarded and in_ready=1 the cycle after rst falls.
- P is derived internally as ~_p+1. All internal sums are DW+1 bits before conditional subtraction of P.
- States: IDLE → MUL → HALF → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register:
    - s = mod_add(a,b)
    - d = mod_sub(a,b): a−b, plus P if a<b
    - w
    - acc=0
    - cnt=DW-1
  - Go to MUL.
- MUL: in_ready=0. Each cycle, MSB-first over w:
  - acc = 2·acc mod P
  - then, if w[cnt], acc = acc + d mod P.
  - Both steps are single conditional subtractions in one cycle.
  - Stay in MUL for exactly DW cycles. After the cnt=0 step, go to HALF.
- HALF (one cycle): for x in {s, acc}, x = x even ? x>>1 : (x+P)>>1, computed at DW+1 bits.
- DONE:
  - out_valid=1; out_a and out_b are held stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE; out_valid=0 the next cycle.
  - out_ready asserted before DONE is ignored.
- Timing:
  - Latency from the accepting edge to out_valid high: DW+1 cycles with halving, DW cycles without.
  - Throughput: one pair per DW+3 cycles (DW+2 without halving) when out_ready is held high.
  - in_ready is high only in IDLE, so a new handshake cannot coincide with DONE.
- Boundaries:
  - a=b gives d=0 and out_b=0 for any w.
  - w=0 gives out_b=0.
  - w=1 gives out_b=d.
  - Operands ≥P are out of contract; outputs are undefined but the FSM still completes.

Optional Feature:
- INTT_HALF_EN.
  - Defined: the HALF state exists and outputs are multiplied by 2^-1 mod P.
  - Undefined: HALF is removed, MUL goes directly to DONE, outputs are unscaled, and latency is DW.

Decomposition:
- ntt_define.vh:
  - Holds `datawidth.
  - Add the FSM state encodings as `define constants (GS_IDLE, GS_MUL, GS_HALF, GS_DONE) shared with the future INTT controller.
- Reuse the existing mod_add for s and for the accumulate step.
- Add one new sub-module, mod_sub: combinational, ports in1, in2, _p, out, matching mod_add's interface. It is also reused for the 2·acc reduction via conditional subtract.

Test Plan (P=12289, _p=~12289+1, INTT_HALF_EN defined unless noted):
- a=5, b=3, w=1 → out_a=4, out_b=1; out_valid exactly DW+1 cycles after handshake.
- a=3, b=5, w=1 → out_a=4, out_b=12288 (d wraps to 12287, odd halving).
- a=12288, b=12288, w=12288 → out_a=12288, out_b=0.
- a=2, b=0, w=12288 → out_a=1, out_b=12288. Without INTT_HALF_EN: out_a=2, out_b=12287, latency DW.
- a=1, b=0, w=2 with out_ready held low 10 cycles after DONE → out_a=6145, out_b=1, held stable; in_ready=0 throughout; IDLE one cycle after out_ready.
- rst pulsed for 1 cycle mid-MUL → out_valid never rises for that pair; in_ready=1 the next cycle; the following pair a=5, b=3, w=1 yields 4, 1.
- 100 random in-range triples checked against golden ((a+b)·inv2)%P and (((a−b+P)%P·w)·inv2)%P, inv2=6145.
